// File: rtl/morph_filter_if.sv
// Pixel stream bundle for morph_filter: input handshake, frame sync, mode select and registered output.
// The slave modport is the filter's view; the master modport is the source/sink view.
interface morph_filter_if;
    logic mode;
    logic in_valid;
    logic in_ready;
    logic in_sof;
    logic in_pix;
    logic out_valid;
    logic out_sof;
    logic out_pix;

    modport master (
        output mode, in_valid, in_sof, in_pix,
        input  in_ready, out_valid, out_sof, out_pix
    );

    modport slave (
        input  mode, in_valid, in_sof, in_pix,
        output in_ready, out_valid, out_sof, out_pix
    );
endinterface

// File: rtl/morph_filter.sv
// Streaming binary dilation/erosion over a WIN_SIZE x WIN_SIZE window with border padding and an end-of-frame flush.
// Erosion and the mode input are built only when MORPH_ERODE_EN is defined; otherwise the block always dilates.
module morph_filter #(
    parameter int H_IMG_RES = 640,
    parameter int V_IMG_RES = 480,
    parameter int WIN_SIZE  = 5,
    parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'b01110_11111_11111_11111_01110
) (
    input  logic          clk,
    input  logic          rst_n,
    morph_filter_if.slave bus
);
    localparam int R  = WIN_SIZE / 2;
    localparam int D  = R * H_IMG_RES + R;
    localparam int NT = WIN_SIZE * WIN_SIZE;
    localparam int XW = (H_IMG_RES > 1) ? $clog2(H_IMG_RES) : 1;
    localparam int YW = (V_IMG_RES > 1) ? $clog2(V_IMG_RES) : 1;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [XW-1:0]        in_x_r, out_x_r, wr_x_s;
    logic [YW-1:0]        in_y_r, out_y_r;
    logic [CW-1:0]        cnt_r;
    logic [NT-1:0]        win_r, next_win_s, tap_s;
    logic [H_IMG_RES-1:0] lb_r [WIN_SIZE-1];
    logic                 in_ready_r, out_valid_r, out_sof_r, out_pix_r;
    logic                 accept_s, sof_acc_s, last_in_s;
    logic                 shift_s, emit_s, restart_s;
    logic                 erode_s, pix_s, result_s;

    function automatic logic dilate_f(input logic [NT-1:0] taps);
        return |(taps & STRUCT_ELM);
    endfunction

    assign accept_s  = bus.in_valid && in_ready_r;
    assign sof_acc_s = accept_s && bus.in_sof;
    assign last_in_s = (in_x_r == XW'(H_IMG_RES - 1)) && (in_y_r == YW'(V_IMG_RES - 1));
    assign wr_x_s    = restart_s ? {XW{1'b0}} : in_x_r;
    // During flush the neutral padding value stands in for missing input.
    assign pix_s     = (state_r == S_FLUSH) ? erode_s : bus.in_pix;

`ifdef MORPH_ERODE_EN
    logic erode_r;

    function automatic logic erode_f(input logic [NT-1:0] taps);
        return &(taps | ~STRUCT_ELM);
    endfunction

    // Mode is captured only together with an accepted frame-start pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            erode_r <= 1'b0;
        end else if (restart_s) begin
            erode_r <= bus.mode;
        end else begin
            erode_r <= erode_r;
        end
    end

    assign erode_s  = erode_r;
    assign result_s = erode_r ? erode_f(tap_s) : dilate_f(tap_s);
`else
    assign erode_s  = 1'b0;
    assign result_s = dilate_f(tap_s);
`endif

    // Next window: shift columns left, new column from line buffers plus the incoming pixel; mask taps outside the frame.
    always_comb begin
        next_win_s = {NT{1'b0}};
        tap_s      = {NT{1'b0}};
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                if (c < WIN_SIZE - 1) begin
                    next_win_s[WIN_SIZE*r+c] = win_r[WIN_SIZE*r+c+1];
                end else if (r < WIN_SIZE - 1) begin
                    next_win_s[WIN_SIZE*r+c] = lb_r[r][wr_x_s];
                end else begin
                    next_win_s[WIN_SIZE*r+c] = pix_s;
                end
            end
        end
        // Taps are judged against the output centre, so line wrap and top/bottom rows fall outside naturally.
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                if ((int'(out_x_r) + c >= R) && (int'(out_x_r) + c < H_IMG_RES + R) &&
                    (int'(out_y_r) + r >= R) && (int'(out_y_r) + r < V_IMG_RES + R)) begin
                    tap_s[WIN_SIZE*r+c] = next_win_s[WIN_SIZE*r+c];
                end else begin
                    tap_s[WIN_SIZE*r+c] = erode_s;
                end
            end
        end
    end

    // Frame sequencing: next state and per-cycle shift/emit/restart decisions.
    always_comb begin
        state_s   = state_r;
        shift_s   = 1'b0;
        emit_s    = 1'b0;
        restart_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (sof_acc_s) begin
                    restart_s = 1'b1;
                    shift_s   = 1'b1;
                    state_s   = S_FILL;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_FILL: begin
                if (sof_acc_s) begin
                    restart_s = 1'b1;
                    shift_s   = 1'b1;
                    state_s   = S_FILL;
                end else if (accept_s) begin
                    shift_s   = 1'b1;
                    state_s   = (cnt_r == CW'(D - 1)) ? S_RUN : S_FILL;
                end else begin
                    state_s   = S_FILL;
                end
            end
            S_RUN: begin
                if (sof_acc_s) begin
                    restart_s = 1'b1;
                    shift_s   = 1'b1;
                    state_s   = S_FILL;
                end else if (accept_s) begin
                    shift_s   = 1'b1;
                    emit_s    = 1'b1;
                    state_s   = last_in_s ? S_FLUSH : S_RUN;
                end else begin
                    state_s   = S_RUN;
                end
            end
            S_FLUSH: begin
                shift_s = 1'b1;
                emit_s  = 1'b1;
                state_s = (cnt_r == CW'(D - 1)) ? S_IDLE : S_FLUSH;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, position counters, fill/flush counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_x_r      <= {XW{1'b0}};
            in_y_r      <= {YW{1'b0}};
            out_x_r     <= {XW{1'b0}};
            out_y_r     <= {YW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_pix_r   <= 1'b0;
        end else begin
            state_r <= state_s;

            if (restart_s) begin
                in_x_r <= XW'(1);
                in_y_r <= {YW{1'b0}};
            end else if (shift_s) begin
                in_x_r <= (in_x_r == XW'(H_IMG_RES - 1)) ? {XW{1'b0}} : in_x_r + XW'(1);
                if (in_x_r == XW'(H_IMG_RES - 1)) begin
                    in_y_r <= (in_y_r == YW'(V_IMG_RES - 1)) ? {YW{1'b0}} : in_y_r + YW'(1);
                end else begin
                    in_y_r <= in_y_r;
                end
            end else begin
                in_x_r <= in_x_r;
                in_y_r <= in_y_r;
            end

            if (restart_s) begin
                out_x_r <= {XW{1'b0}};
                out_y_r <= {YW{1'b0}};
            end else if (emit_s) begin
                out_x_r <= (out_x_r == XW'(H_IMG_RES - 1)) ? {XW{1'b0}} : out_x_r + XW'(1);
                if (out_x_r == XW'(H_IMG_RES - 1)) begin
                    out_y_r <= (out_y_r == YW'(V_IMG_RES - 1)) ? {YW{1'b0}} : out_y_r + YW'(1);
                end else begin
                    out_y_r <= out_y_r;
                end
            end else begin
                out_x_r <= out_x_r;
                out_y_r <= out_y_r;
            end

            if (restart_s) begin
                cnt_r <= CW'(1);
            end else if ((state_r == S_FILL) && shift_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else if ((state_r == S_RUN) && (state_s == S_FLUSH)) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == S_FLUSH) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            in_ready_r  <= (state_s != S_FLUSH);
            out_valid_r <= emit_s;
            out_sof_r   <= emit_s && (out_x_r == {XW{1'b0}}) && (out_y_r == {YW{1'b0}});
            out_pix_r   <= emit_s && result_s;
        end
    end

    // Window register advances one column per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r <= {NT{1'b0}};
        end else if (shift_s) begin
            win_r <= next_win_s;
        end else begin
            win_r <= win_r;
        end
    end

    // Line buffers move up one row at the current column; contents before the first write are masked by padding.
    always_ff @(posedge clk) begin
        if (shift_s) begin
            for (int k = 0; k < WIN_SIZE - 1; k++) begin
                lb_r[k][wr_x_s] <= next_win_s[WIN_SIZE*(k+1)+WIN_SIZE-1];
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sof   = out_sof_r;
    assign bus.out_pix   = out_pix_r;
endmodule

// File: tb/tb_morph_filter.sv
// Self-checking bench for morph_filter: two instances (8x6 / 3x3 all-ones SE, 16x12 / default 5x5 SE), a table of
// directed frames, randomized frames with input gaps, a mid-frame restart and a mid-frame reset, all against a window model.
`timescale 1ns/1ps
module tb_morph_filter;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int WA = 3;
    localparam int HB = 16;
    localparam int VB = 12;
    localparam int WB = 5;
    localparam int DA = (WA / 2) * HA + WA / 2;
    localparam int DB = (WB / 2) * HB + WB / 2;
    localparam logic [8:0]  SE_A = 9'h1FF;
    localparam logic [24:0] SE_B = 25'b01110_11111_11111_11111_01110;
`ifdef MORPH_ERODE_EN
    localparam bit ERODE_ON = 1'b1;
`else
    localparam bit ERODE_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sel   = 1'b0;
    logic drv_valid = 1'b0;
    logic drv_sof   = 1'b0;
    logic drv_pix   = 1'b0;
    logic drv_mode  = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   ready_low = 0;
    bit   out_q_pix [$];
    bit   out_q_sof [$];
    bit   img [0:255];

    always #5 clk = ~clk;

    morph_filter_if ifa ();
    morph_filter_if ifb ();

    assign ifa.in_valid = drv_valid && !sel;
    assign ifa.in_sof   = drv_sof;
    assign ifa.in_pix   = drv_pix;
    assign ifa.mode     = drv_mode;
    assign ifb.in_valid = drv_valid && sel;
    assign ifb.in_sof   = drv_sof;
    assign ifb.in_pix   = drv_pix;
    assign ifb.mode     = drv_mode;

    morph_filter #(.H_IMG_RES(HA), .V_IMG_RES(VA), .WIN_SIZE(WA), .STRUCT_ELM(SE_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    morph_filter #(.H_IMG_RES(HB), .V_IMG_RES(VB))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    wire mon_valid = sel ? ifb.out_valid : ifa.out_valid;
    wire mon_sof   = sel ? ifb.out_sof   : ifa.out_sof;
    wire mon_pix   = sel ? ifb.out_pix   : ifa.out_pix;
    wire mon_ready = sel ? ifb.in_ready  : ifa.in_ready;

    always @(negedge clk) begin
        if (mon_valid) begin
            out_q_pix.push_back(mon_pix);
            out_q_sof.push_back(mon_sof);
        end
        if (!mon_ready) ready_low++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Window model straight from the definition: SE-selected neighbours, out-of-frame taps take the neutral value.
    function automatic bit model_px(input int h, input int v, input int w, input logic [80:0] se,
                                    input bit er, input int x, input int y);
        int r;
        bit acc;
        bit p;
        r   = w / 2;
        acc = er;
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                if (se[w*(dy+r) + (dx+r)]) begin
                    if (x + dx >= 0 && x + dx < h && y + dy >= 0 && y + dy < v) p = img[(y+dy)*h + x + dx];
                    else p = er;
                    acc = er ? (acc & p) : (acc | p);
                end
            end
        end
        return acc;
    endfunction

    function automatic void build(input int pat, input int h, input int v);
        for (int i = 0; i < 256; i++) img[i] = 1'b0;
        case (pat)
            0: img[2*h+3] = 1'b1;
            1: for (int i = 0; i < h*v; i++) img[i] = 1'b1;
            2: for (int y = 2; y <= 4; y++) for (int x = 3; x <= 5; x++) img[y*h+x] = 1'b1;
            3: img[0] = 1'b1;
            4: img[11*h+15] = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic void build_random(input int n);
        int dens;
        dens = $urandom_range(85, 15);
        for (int i = 0; i < 256; i++) img[i] = (i < n) && ($urandom_range(99) < dens);
    endfunction

    task automatic send_pixels(input int n, input int gap, input bit md, input bit sof_first);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(99) < gap) begin
                drv_valid = 1'b0;
                drv_sof   = 1'b0;
            end else begin
                drv_valid = 1'b1;
                drv_sof   = sof_first && (k == 0);
                drv_pix   = img[k];
                drv_mode  = (k == 0) ? md : 1'($urandom_range(1));
                if (mon_ready) k++;
            end
        end
        @(negedge clk);
        drv_valid = 1'b0;
        drv_sof   = 1'b0;
        check("send_done", k, n);
    endtask

    task automatic run_frame(input bit s, input bit md, input int gap, output int ones);
        int h, v, w, d, n, q0, r0, cnt, mism, bad, nsof;
        logic [80:0] se;
        bit e;
        h  = s ? HB : HA;
        v  = s ? VB : VA;
        w  = s ? WB : WA;
        d  = s ? DB : DA;
        se = s ? 81'(SE_B) : 81'(SE_A);
        n  = h * v;
        sel = s;
        @(posedge clk); #1;
        q0 = out_q_pix.size();
        r0 = ready_low;
        send_pixels(n, gap, md, 1'b1);
        repeat (d + 6) @(negedge clk);
        @(posedge clk); #1;
        cnt = out_q_pix.size() - q0;
        check($sformatf("out_count_s%0d", s), cnt, n);
        check($sformatf("ready_low_s%0d", s), ready_low - r0, d);
        mism = 0; ones = 0; nsof = 0; bad = -1;
        for (int i = 0; i < cnt && i < n; i++) begin
            e = model_px(h, v, w, se, md && ERODE_ON, i % h, i / h);
            if (out_q_pix[q0+i] != e) begin
                mism++;
                if (bad < 0) bad = i;
            end
            ones += int'(out_q_pix[q0+i]);
            nsof += int'(out_q_sof[q0+i]);
        end
        check($sformatf("frame_data_s%0d_md%0d_first_bad%0d", s, md, bad), mism, 0);
        check("sof_count", nsof, 1);
        check("sof_first", (cnt > 0) ? int'(out_q_sof[q0]) : 0, 1);
    endtask

    typedef struct {
        bit s;
        bit md;
        int pat;
        int exp_ones;
        int exp_cnt;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   ones, q0, mism, h0;
        vecs[0] = '{1'b0, 1'b0, 0, 9, 48};
        vecs[1] = '{1'b0, 1'b1, 1, 48, 48};
        vecs[2] = '{1'b0, 1'b1, 2, ERODE_ON ? 1 : 25, 48};
        vecs[3] = '{1'b1, 1'b0, 3, 8, 192};
        vecs[4] = '{1'b1, 1'b0, 4, 8, 192};
        vecs[5] = '{1'b0, 1'b1, 5, 0, 48};

        repeat (3) @(negedge clk);
        check("rst_ready_a", int'(ifa.in_ready), 1);
        check("rst_valid_a", int'(ifa.out_valid), 0);
        check("rst_sof_a", int'(ifa.out_sof), 0);
        check("rst_pix_a", int'(ifa.out_pix), 0);
        check("rst_ready_b", int'(ifb.in_ready), 1);
        check("rst_valid_b", int'(ifb.out_valid), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            build(vecs[i].pat, vecs[i].s ? HB : HA, vecs[i].s ? VB : VA);
            q0 = out_q_pix.size();
            run_frame(vecs[i].s, vecs[i].md, 0, ones);
            check($sformatf("vec%0d_ones", i), ones, vecs[i].exp_ones);
            check($sformatf("vec%0d_count", i), out_q_pix.size() - q0, vecs[i].exp_cnt);
        end

        for (int i = 0; i < 6; i++) begin
            build_random((i % 2) ? HB * VB : HA * VA);
            run_frame(1'(i % 2), 1'($urandom_range(1)), (i < 2) ? 0 : 40, ones);
        end

        // Restart at pixel 20: the aborted frame stops after 11 outputs, then a clean frame follows.
        sel = 1'b0;
        build_random(HA * VA);
        @(posedge clk); #1;
        q0 = out_q_pix.size();
        send_pixels(20, 0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        check("abort_count", out_q_pix.size() - q0, 11);
        mism = 0;
        for (int i = 0; i < 11 && q0 + i < out_q_pix.size(); i++) begin
            if (out_q_pix[q0+i] != model_px(HA, VA, WA, 81'(SE_A), 1'b0, i % HA, i / HA)) mism++;
        end
        check("abort_data", mism, 0);
        build_random(HA * VA);
        run_frame(1'b0, 1'b0, 0, ones);

        // Reset in mid-frame, then pixels without a frame start are ignored.
        build_random(HA * VA);
        @(posedge clk); #1;
        send_pixels(30, 0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(ifa.out_valid), 0);
        check("midrst_ready", int'(ifa.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        h0 = out_q_pix.size();
        send_pixels(20, 0, 1'b0, 1'b0);
        repeat (DA + 4) @(negedge clk);
        @(posedge clk); #1;
        check("no_sof_dropped", out_q_pix.size() - h0, 0);
        build_random(HA * VA);
        run_frame(1'b0, 1'b0, 20, ones);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/morph_filter.md
# morph_filter

Parametrised streaming binary morphology filter: dilation or erosion of a 1-bit foreground mask by a programmable structuring element over a WIN_SIZE×WIN_SIZE window. It sits after the motion-segmentation threshold stage and before blob labelling. It replaces the fixed dilator with a valid/ready pixel stream, frame-start sync, neutral border padding and an end-of-frame flush, so the full frame is emitted in raster order.

## Interface
- H_IMG_RES, 640: pixels per line.
- V_IMG_RES, 480: lines per frame.
- WIN_SIZE, 5: window side; odd, 3..9. R = WIN_SIZE/2.
- STRUCT_ELM, 25'b01110_11111_11111_11111_01110: structuring element. Bit WIN_SIZE*r+c is window row r, column c; row 0, column 0 is top-left.
- clk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = dilate, 1 = erode. Sampled only on an accepted in_sof pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_sof  in  1  marks the first pixel (0,0) of a frame.
- in_pix  in  1  input mask pixel.
- out_valid  out  1  output pixel valid. No backpressure; the sink must always accept.
- out_sof  out  1  marks output pixel (0,0).
- out_pix  out  1  filtered pixel.

## Operation
- Accept means in_valid && in_ready.
- Storage: WIN_SIZE−1 line buffers of H_IMG_RES bits, plus a WIN_SIZE×WIN_SIZE window shift register.
- Counters: in_x, in_y for input position; out_x, out_y for output position. Each is ceil_log2(res) bits wide and wraps at H_IMG_RES or V_IMG_RES.
- Delay: output pixel (x,y) is computed when input linear index y·H+x+D has been accepted, where D = R·H_IMG_RES+R.
- Padding: window taps outside the frame (x±R or y±R out of range, including horizontal wrap between lines) are forced to 0 in dilate mode and to 1 in erode mode.
- Result:
  - Dilate: out = OR over (STRUCT_ELM & window).
  - Erode: out = AND over (window | ~STRUCT_ELM).
- FSM states:
  - IDLE: in_ready=1. An accepted pixel with in_sof goes to FILL; counters reset to (1,0) and mode is latched. Accepted pixels without in_sof are dropped.
  - FILL: in_ready=1. Accepts the first D pixels with no output, then goes to RUN.
  - RUN: in_ready=1. Each accepted pixel yields exactly one output. Accepting the last pixel (H−1,V−1) goes to FLUSH.
  - FLUSH: in_ready=0. Emits the remaining D outputs one per cycle using padding in place of further input, then goes to IDLE.
- Mid-frame in_sof: an accepted in_sof in FILL or RUN aborts the current frame with no further outputs from it and restarts as from IDLE.
- mode changes outside in_sof have no effect until the next frame.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sof=0, out_pix=0, FSM=IDLE, counters 0. Line buffer contents are don't-care, because padding masks them until they are written.
- Latency: out_valid rises exactly 1 cycle after the accept that completes the window, so output is registered.
- out_sof coincides with the first out_valid of each frame.
- Throughput: 1 pixel/cycle sustained. Gaps in in_valid stall the pipeline without loss.
- FLUSH lasts exactly D cycles with out_valid=1 every cycle. in_ready returns to 1 in the cycle after the last flush output.
- Each complete frame yields exactly H·V outputs.
- Reset asserted mid-operation clears state immediately. The partial frame is lost and no out_valid is generated until the next in_sof.

## Configuration
- MORPH_ERODE_EN defined: erode mode and the mode port behaviour are available as described above.
- MORPH_ERODE_EN undefined: erosion logic is not built. The mode port is present but ignored, the block always dilates, and padding is always 0.

## Test plan
- Parameters H=8, V=6, WIN_SIZE=3, SE all ones, dilate. Single 1 at (3,2) -> out_pix=1 exactly at x=2..4, y=1..3 (9 pixels); the other 39 outputs are 0; 48 out_valid total.
- Same parameters, erode. All-ones frame -> all 48 outputs 1 (border padding neutral). 3×3 ones block centred at (4,3) -> only (4,3)=1.
- Default parameters, dilate. Pixel at (0,0) -> outputs 1 at (0..2,0..1) and (0..1,2). No wrap artefacts at x=637..639 of the previous line or y=479.
- in_valid toggling 1-0-1 randomly -> output sequence identical to the continuous run. in_ready=0 for exactly D=9 cycles (H=8, R=1) at frame end.
- in_sof reasserted at pixel 20 of frame -> the aborted frame emits exactly 11 outputs, and the new frame produces 48 correct outputs with out_sof on the first.
- rst_n pulsed low during RUN -> out_valid=0 next cycle, in_ready=1, FSM IDLE. Pixels without in_sof are dropped until the next in_sof.
